pixel_frame_tx: RTL and testbench

- Transmit-side framer for the pixel link: buffers incoming pixels and emits one frame per pixel burst.
- Frame format, one word per cycle, no gaps: 16'hFFFF, 16'hFFFF, 16'hAAAA, control word, then exactly NUM_PIXEL pixel words.
- Sits upstream of the pixel receive/pick block. DOUT drives its data input; TX_VALID drives its rcvReady.

---
 rtl/pixel_frame_tx_if.sv | 25 ++
 rtl/pixel_frame_tx.sv | 104 ++++++++++
 tb/tb_pixel_frame_tx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_frame_tx_if.sv
// Pixel-side and frame-side signal bundle for the pixel link transmit framer.
// The master drives pixels and frame control; the slave is the framer itself.
interface pixel_frame_tx_if #(
  parameter int PIXEL_WIDTH = 16
);
  logic [PIXEL_WIDTH-1:0] PIX_DIN;
  logic                   PIX_VALID;
  logic                   PIX_READY;
  logic                   TX_EN;
  logic [PIXEL_WIDTH-1:0] CNTL_WORD;
  logic                   TX_VALID;
  logic [PIXEL_WIDTH-1:0] DOUT;
  logic                   FRAME_BUSY;
  logic                   FRAME_DONE;

  modport master (
    output PIX_DIN, PIX_VALID, TX_EN, CNTL_WORD,
    input  PIX_READY, TX_VALID, DOUT, FRAME_BUSY, FRAME_DONE
  );

  modport slave (
    input  PIX_DIN, PIX_VALID, TX_EN, CNTL_WORD,
    output PIX_READY, TX_VALID, DOUT, FRAME_BUSY, FRAME_DONE
  );
endinterface

// File: rtl/pixel_frame_tx.sv
// Transmit framer: buffers NUM_PIXEL pixels in a circular FIFO, then emits
// SYNC, SYNC, MARK, control word and the buffered pixels back to back.
module pixel_frame_tx #(
  parameter int                     PIXEL_WIDTH = 16,
  parameter int                     NUM_PIXEL   = 16,
  parameter logic [PIXEL_WIDTH-1:0] SYNC_WORD   = 16'hFFFF,
  parameter logic [PIXEL_WIDTH-1:0] MARK_WORD   = 16'hAAAA
) (
  input  logic             CLK,
  input  logic             RST,
  pixel_frame_tx_if.slave  bus
);

  localparam int PW = (NUM_PIXEL > 1) ? $clog2(NUM_PIXEL) : 1;
  localparam int CW = $clog2(NUM_PIXEL + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NUM_PIXEL - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NUM_PIXEL);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_MARK, S_CNTL, S_PIXEL
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [PW-1:0]          r_pix_cnt;
  logic [PW-1:0]          r_rd_ptr;
  logic [PW-1:0]          r_wr_ptr;
  logic [CW-1:0]          r_count;
  logic [PIXEL_WIDTH-1:0] r_ctrl;
  logic [PIXEL_WIDTH-1:0] r_mem [NUM_PIXEL];

  logic                   w_full;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_last;
  logic                   w_start;
  logic [PIXEL_WIDTH-1:0] w_dout;

  assign w_full  = (r_count == CNT_FULL);
  assign w_wr    = bus.PIX_VALID && !w_full;
  assign w_rd    = (r_state == S_PIXEL);
  assign w_last  = w_rd && (r_pix_cnt == PTR_LAST);
  assign w_start = (r_state == S_IDLE) && bus.TX_EN && w_full;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_next = S_SYNC0;
      S_SYNC0: w_state_next = S_SYNC1;
      S_SYNC1: w_state_next = S_MARK;
      S_MARK:  w_state_next = S_CNTL;
      S_CNTL:  w_state_next = S_PIXEL;
      S_PIXEL: if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_pix_cnt <= '0;
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_count   <= '0;
      r_ctrl    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_start) r_ctrl <= bus.CNTL_WORD;
      if (w_rd) begin
        r_pix_cnt <= w_last ? '0 : r_pix_cnt + 1'b1;
        r_rd_ptr  <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_wr) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      // A read only happens while a full frame's worth is buffered, so no underflow.
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= bus.PIX_DIN;
  end

  always_comb begin
    w_dout = '0;
    case (r_state)
      S_SYNC0, S_SYNC1: w_dout = SYNC_WORD;
      S_MARK:           w_dout = MARK_WORD;
      S_CNTL:           w_dout = r_ctrl;
      S_PIXEL:          w_dout = r_mem[r_rd_ptr];
      default:          w_dout = '0;
    endcase
  end

  assign bus.DOUT       = w_dout;
  assign bus.TX_VALID   = (r_state != S_IDLE);
  assign bus.FRAME_BUSY = (r_state != S_IDLE);
  assign bus.FRAME_DONE = w_last;
  assign bus.PIX_READY  = !w_full;

endmodule

// File: tb/tb_pixel_frame_tx.sv
// Bench for pixel_frame_tx: directed and random stimulus compared each cycle
// against a queue-based model of the frame format and pixel buffer.
module tb_pixel_frame_tx;

  localparam int          N    = 16;
  localparam logic [15:0] SYNC = 16'hFFFF;
  localparam logic [15:0] MARK = 16'hAAAA;

  logic clk;
  logic rst;

  pixel_frame_tx_if #(.PIXEL_WIDTH(16)) bus ();

  pixel_frame_tx #(
    .PIXEL_WIDTH(16),
    .NUM_PIXEL  (N),
    .SYNC_WORD  (SYNC),
    .MARK_WORD  (MARK)
  ) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;
  int run_len;
  bit aborted;

  // Model: pix_q is the buffer contents, frm_q the words of the frame still to be shown.
  logic [15:0] pix_q[$];
  logic [15:0] frm_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    logic        acc;
    logic [15:0] dummy;
    if (rst) begin
      pix_q.delete();
      frm_q.delete();
      if (run_len != 0) aborted = 1'b1;
    end else begin
      acc = bus.PIX_VALID && (pix_q.size() != N);
      if (frm_q.size() != 0) begin
        if (frm_q.size() <= N) dummy = pix_q.pop_front();
        dummy = frm_q.pop_front();
      end else if (bus.TX_EN && pix_q.size() == N) begin
        frm_q = {SYNC, SYNC, MARK, bus.CNTL_WORD};
        foreach (pix_q[i]) frm_q.push_back(pix_q[i]);
      end
      if (acc) pix_q.push_back(bus.PIX_DIN);
    end
    @(posedge clk);
    #1;
    check("tx_valid",   32'(bus.TX_VALID),   32'(frm_q.size() != 0));
    check("frame_busy", 32'(bus.FRAME_BUSY), 32'(frm_q.size() != 0));
    check("dout",       32'(bus.DOUT),       (frm_q.size() != 0) ? 32'(frm_q[0]) : 32'h0);
    check("frame_done", 32'(bus.FRAME_DONE), 32'(frm_q.size() == 1));
    check("pix_ready",  32'(bus.PIX_READY),  32'(pix_q.size() != N));
    if (bus.TX_VALID === 1'b1) begin
      run_len++;
    end else begin
      if (run_len != 0 && !aborted) check("frame_len", 32'(run_len), 32'(N + 4));
      run_len = 0;
      aborted = 1'b0;
    end
  endtask

  function automatic logic [15:0] pick_pixel();
    case ($urandom_range(0, 3))
      0:       return SYNC;
      1:       return MARK;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    vectors       = 0;
    miscompares   = 0;
    run_len       = 0;
    aborted       = 1'b0;
    rst           = 1'b1;
    bus.PIX_VALID = 1'b1;
    bus.PIX_DIN   = 16'h5555;
    bus.TX_EN     = 1'b0;
    bus.CNTL_WORD = 16'h0;

    // Reset held two cycles while a pixel is offered
    step();
    step();
    check("rst_tx_valid", 32'(bus.TX_VALID),  32'h0);
    check("rst_dout",     32'(bus.DOUT),      32'h0);
    check("rst_busy",     32'(bus.FRAME_BUSY), 32'h0);
    check("rst_ready",    32'(bus.PIX_READY), 32'h1);
    rst = 1'b0;
    bus.PIX_VALID = 1'b0;

    // Basic frame: pixels 1..16, control 1234
    for (int i = 1; i <= N; i++) begin
      bus.PIX_VALID = 1'b1;
      bus.PIX_DIN   = 16'(i);
      step();
    end
    bus.PIX_VALID = 1'b0;
    bus.TX_EN     = 1'b1;
    bus.CNTL_WORD = 16'h1234;
    step();
    check("basic_first_sync", 32'(bus.DOUT), 32'hFFFF);
    for (int i = 0; i < 23; i++) step();
    bus.TX_EN = 1'b0;

    // Backpressure: 17 offers with TX_EN low
    bus.PIX_VALID = 1'b1;
    for (int i = 0; i < N + 1; i++) begin
      bus.PIX_DIN = pick_pixel();
      step();
    end
    check("bp_ready_low", 32'(bus.PIX_READY), 32'h0);
    for (int i = 0; i < 3; i++) step();
    bus.PIX_VALID = 1'b0;
    bus.TX_EN     = 1'b1;
    bus.CNTL_WORD = 16'hBEEF;
    for (int i = 0; i < 24; i++) step();

    // Concurrent refill across several frames and pointer wraps
    bus.PIX_VALID = 1'b1;
    for (int i = 0; i < 90; i++) begin
      bus.PIX_DIN   = pick_pixel();
      bus.CNTL_WORD = 16'($urandom);
      step();
    end
    bus.PIX_VALID = 1'b0;
    bus.TX_EN     = 1'b0;
    for (int i = 0; i < 22; i++) step();

    // Reset in the middle of the pixel phase
    bus.PIX_VALID = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.PIX_DIN = pick_pixel();
      step();
    end
    bus.PIX_VALID = 1'b0;
    bus.TX_EN     = 1'b1;
    for (int i = 0; i < 9; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.TX_EN = 1'b0;
    check("midrst_tx_valid", 32'(bus.TX_VALID), 32'h0);
    check("midrst_ready",    32'(bus.PIX_READY), 32'h1);
    step();

    // TX_EN dropped while MARK is on the line
    bus.PIX_VALID = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.PIX_DIN = pick_pixel();
      step();
    end
    bus.PIX_VALID = 1'b0;
    bus.TX_EN     = 1'b1;
    step();
    step();
    step();
    check("mark_on_line", 32'(bus.DOUT), 32'hAAAA);
    bus.TX_EN = 1'b0;
    for (int i = 0; i < 22; i++) step();

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bus.PIX_VALID = ($urandom_range(0, 3) != 0);
      bus.PIX_DIN   = pick_pixel();
      bus.TX_EN     = ($urandom_range(0, 2) != 0);
      bus.CNTL_WORD = pick_pixel();
      rst           = ($urandom_range(0, 299) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
